// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : aes_pkg                                                      |
// | Description : Shared AES types for the column-mix scheduler: full/half     |
// |               state types, scheduler FSM encoding, requester count and the |
// |               GF(2^8) doubling helper used by the column mixer.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int REQ_NUM = 2;

    typedef logic [127:0] aes_state_t;
    typedef logic [63:0]  aes_half_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MIX_HI = 2'd1,
        MIX_LO = 2'd2,
        RESP   = 2'd3
    } sched_state_e;

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixcol.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mixcol                                                       |
// | Description : Purely combinational AES MixColumns on two 32-bit columns.   |
// |               Column 0 sits in i_data[63:32]; byte 0 of each column is in  |
// |               the column's most significant byte.                          |
// | Ports       : i_data  [63:0]  two input columns                            |
// |               o_data  [63:0]  two mixed columns                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mixcol
    import aes_pkg::*;
(
    input  aes_half_t i_data,
    output aes_half_t o_data
);

    for (genvar c = 0; c < 2; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        logic [7:0] w_x0, w_x1, w_x2, w_x3;

        assign w_a0 = i_data[63 - 32*c -: 8];
        assign w_a1 = i_data[55 - 32*c -: 8];
        assign w_a2 = i_data[47 - 32*c -: 8];
        assign w_a3 = i_data[39 - 32*c -: 8];

        assign w_x0 = gf_xtime(w_a0);
        assign w_x1 = gf_xtime(w_a1);
        assign w_x2 = gf_xtime(w_a2);
        assign w_x3 = gf_xtime(w_a3);

        // 3*a is expressed as xtime(a) ^ a.
        assign o_data[63 - 32*c -: 8] = w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3;
        assign o_data[55 - 32*c -: 8] = w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3;
        assign o_data[47 - 32*c -: 8] = w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3;
        assign o_data[39 - 32*c -: 8] = w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3;
    end

endmodule
`default_nettype wire

// File: rtl/mix_col_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mix_col_sched                                                |
// | Description : Shares one 64-bit column mixer between two requesters.       |
// |               A 128-bit state is mixed in two beats (high half, then low   |
// |               half) and returned with the owning requester ID. A skip      |
// |               request bypasses the mixer (final AES round).                |
// | Ports       : clk, rst            clock, synchronous active-high reset     |
// |               reqN_valid/ready    request handshake, N = 0 (round engine), |
// |                                   N = 1 (RISC-V AES instruction unit)      |
// |               reqN_state/skip     state to mix, bypass flag                |
// |               resp_valid/ready    response handshake                       |
// |               resp_data/id        result and owning requester              |
// |               busy                high whenever not idle                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mix_col_sched
    import aes_pkg::*;
#(
    parameter int ID_W    = 1,
    parameter int STATE_W = 128
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [STATE_W-1:0] req0_state,
    input  logic               req0_skip,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [STATE_W-1:0] req1_state,
    input  logic               req1_skip,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [STATE_W-1:0] resp_data,
    output logic [ID_W-1:0]    resp_id,
    output logic               busy
);

    sched_state_e    r_state, w_state_nxt;
    logic            r_ptr, w_ptr_nxt;      // 0: requester 0 wins a tie
    aes_state_t      r_data, w_data_nxt;    // latched input state
    aes_state_t      r_result, w_result_nxt;
    logic [ID_W-1:0] r_id, w_id_nxt;

    logic            w_gnt0, w_gnt1, w_accept;
    aes_half_t       w_mix_in, w_mix_out;

    // Arbitration: a lone valid wins, a tie goes to the pointer.
    assign w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
    assign w_gnt1 = req1_valid & (~req0_valid |  r_ptr);

    assign req0_ready = (r_state == IDLE) & ~rst & w_gnt0;
    assign req1_ready = (r_state == IDLE) & ~rst & w_gnt1;
    assign w_accept   = req0_ready | req1_ready;

    assign resp_valid = (r_state == RESP);
    assign resp_data  = r_result;
    assign resp_id    = r_id;
    assign busy       = (r_state != IDLE);

    mixcol u_mixcol (
        .i_data (w_mix_in),
        .o_data (w_mix_out)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_data_nxt   = r_data;
        w_result_nxt = r_result;
        w_id_nxt     = r_id;
        w_mix_in     = '0;   // mixer quiet outside the two mix beats

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_data_nxt = w_gnt1 ? req1_state : req0_state;
                    w_id_nxt   = ID_W'(w_gnt1);
                    // Hand the tie-break to whoever lost this round.
                    w_ptr_nxt  = ~w_gnt1;
                    if (w_gnt1 ? req1_skip : req0_skip) begin
                        w_result_nxt = w_gnt1 ? req1_state : req0_state;
                        w_state_nxt  = RESP;
                    end else begin
                        w_state_nxt  = MIX_HI;
                    end
                end
            end
            MIX_HI: begin
                w_mix_in              = r_data[127:64];
                w_result_nxt[127:64]  = w_mix_out;
                w_state_nxt           = MIX_LO;
            end
            MIX_LO: begin
                w_mix_in              = r_data[63:0];
                w_result_nxt[63:0]    = w_mix_out;
                w_state_nxt           = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_data   <= '0;
            r_result <= '0;
            r_id     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_data   <= w_data_nxt;
            r_result <= w_result_nxt;
            r_id     <= w_id_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_col_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_mix_col_sched                                             |
// | Description : Scoreboard bench for mix_col_sched. Accepted requests push   |
// |               the reference result (GF(2^8) matrix product) into a queue;  |
// |               a negedge monitor pops and compares on every response.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mix_col_sched;

    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   v;
    logic [1:0]   sk;
    logic [127:0] st0, st1;
    logic         rdy;
    logic         req0_ready, req1_ready;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic [0:0]   resp_id;
    logic         busy;

    always #5 clk = ~clk;

    mix_col_sched #(.ID_W(1), .STATE_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_ready (req0_ready),
        .req0_state (st0),
        .req0_skip  (sk[0]),
        .req1_valid (v[1]),
        .req1_ready (req1_ready),
        .req1_state (st1),
        .req1_skip  (sk[1]),
        .resp_valid (resp_valid),
        .resp_ready (rdy),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    typedef struct {
        logic [127:0] d;
        logic         id;
        int           acyc;
    } exp_t;

    exp_t         exp_q[$];
    logic         grant_log[$];
    int           n_cmp = 0, n_bad = 0;
    int           cyc = 0, resp_cnt = 0, rise_cyc = 0, last_lat = 0;
    logic [127:0] last_data = '0;
    logic         last_id = 1'b0;
    logic         prev_rv = 1'b0;
    logic         ptr_m = 1'b0;

    function automatic void check(input bit ok, input string name,
                                  input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // out[r] of each column = sum_k M[r][k] * in[k], M circulant of (2,3,1,1).
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        int           coef[4];
        coef = '{2, 3, 1, 1};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[127 - 8*(4*c + k) -: 8], 8'(coef[(k - r + 4) % 4]));
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Monitor / scoreboard
    initial begin
        logic a0, a1, id;
        logic [127:0] s;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                ptr_m   = 1'b0;
                prev_rv = 1'b0;
            end else begin
                a0 = v[0] && req0_ready;
                a1 = v[1] && req1_ready;
                if (a0 || a1) begin
                    check(!(a0 && a1), "grant_onehot", {a0, a1}, 128'd0);
                    id = a1;
                    if (v[0] && v[1]) check(id == ptr_m, "rr_grant", id, ptr_m);
                    ptr_m = ~id;
                    s = a1 ? st1 : st0;
                    e.d    = (a1 ? sk[1] : sk[0]) ? s : mix_ref(s);
                    e.id   = id;
                    e.acyc = cyc;
                    exp_q.push_back(e);
                    grant_log.push_back(id);
                end
                if (resp_valid && !prev_rv) rise_cyc = cyc;
                if (resp_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "resp_unexpected", resp_data, 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check(resp_data == e.d, "resp_data", resp_data, e.d);
                        check(resp_id[0] == e.id, "resp_id", resp_id, e.id);
                        last_lat = rise_cyc - e.acyc;
                    end
                    last_data = resp_data;
                    last_id   = resp_id[0];
                    resp_cnt++;
                end
                prev_rv = resp_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int r);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (r == 0) ? (v[0] && req0_ready) : (v[1] && req1_ready);
            tick();
        end
        if (!got) check(1'b0, "accept_timeout", r, 128'd0);
        v[r] = 1'b0;
    endtask

    task automatic send(input int r, input logic [127:0] s, input logic k);
        if (r == 0) st0 = s; else st1 = s;
        sk[r] = k;
        v[r]  = 1'b1;
        wait_acc(r);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 300) begin
            tick();
            i++;
        end
        check(exp_q.size() == 0 && !busy, "drain", exp_q.size(), 128'd0);
    endtask

    task automatic run_traffic(input int n0, input int n1, input int gap, input int stall);
        int           left[2];
        bit           acc[2];
        int           t;
        logic [127:0] s;
        logic         k;
        left[0] = n0;
        left[1] = n1;
        t = 0;
        while ((left[0] > 0 || left[1] > 0 || v != 2'b00) && t < LIMIT) begin
            @(negedge clk);
            acc[0] = v[0] && req0_ready;
            acc[1] = v[1] && req1_ready;
            tick();
            t++;
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) v[r] = 1'b0;
                if (!v[r] && left[r] > 0 && $urandom_range(0, 99) >= gap) begin
                    s = {$urandom, $urandom, $urandom, $urandom};
                    k = ($urandom_range(0, 3) == 0);
                    if (r == 0) st0 = s; else st1 = s;
                    sk[r] = k;
                    v[r]  = 1'b1;
                    left[r]--;
                end
            end
            rdy = ($urandom_range(0, 99) >= stall);
        end
        if (t >= LIMIT) check(1'b0, "traffic_timeout", t, LIMIT);
        rdy = 1'b1;
    endtask

    initial begin
        int           cnt0;
        bit           seen;
        logic [127:0] sb;
        rst = 1'b1;
        v   = 2'b00;
        sk  = 2'b00;
        st0 = '0;
        st1 = '0;
        rdy = 1'b1;
        tick();
        tick();
        // Reset state
        check(!resp_valid, "reset_resp_valid", resp_valid, 128'd0);
        check(resp_data == '0, "reset_resp_data", resp_data, 128'd0);
        check(!busy, "reset_busy", busy, 128'd0);
        rst = 1'b0;

        // req0 alone, mix
        send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
        drain();
        check(last_data == 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "vec_mix_data",
              last_data, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check(last_id == 1'b0, "vec_mix_id", last_id, 128'd0);
        check(last_lat == 3, "vec_mix_latency", last_lat, 128'd3);

        // req1 alone, skip
        send(1, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
        drain();
        check(last_data == 128'h00112233_44556677_8899aabb_ccddeeff, "vec_skip_data",
              last_data, 128'h00112233_44556677_8899aabb_ccddeeff);
        check(last_id == 1'b1, "vec_skip_id", last_id, 128'd1);
        check(last_lat == 1, "vec_skip_latency", last_lat, 128'd1);

        // Both valid every cycle from reset: grants must alternate 0,1,0,1...
        do_reset();
        grant_log.delete();
        run_traffic(4, 4, 0, 0);
        drain();
        check(grant_log.size() == 8, "alt_count", grant_log.size(), 128'd8);
        for (int i = 0; i < grant_log.size() && i < 8; i++)
            check(grant_log[i] == i[0], "alt_order", grant_log[i], i[0]);

        // Backpressure: stalled response blocks both requesters
        rdy = 1'b0;
        cnt0 = resp_cnt;
        send(0, 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        check(seen, "bp_resp_timeout", seen, 128'd1);
        st1   = {$urandom, $urandom, $urandom, $urandom};
        sk[1] = 1'b0;
        v[1]  = 1'b1;
        v[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(resp_valid, "bp_valid_held", resp_valid, 128'd1);
            check(resp_data == 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8, "bp_data_held",
                  resp_data, 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8);
            check({req0_ready, req1_ready} == 2'b00, "bp_readys_low",
                  {req0_ready, req1_ready}, 128'd0);
        end
        v[0] = 1'b0;
        tick();
        rdy = 1'b1;
        wait_acc(1);
        drain();
        check(resp_cnt - cnt0 == 2, "bp_handshakes", resp_cnt - cnt0, 128'd2);

        // Reset during MIX_LO aborts the in-flight operation
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        tick();
        rst   = 1'b1;
        st0   = {$urandom, $urandom, $urandom, $urandom};
        sb    = {$urandom, $urandom, $urandom, $urandom};
        st1   = sb;
        sk    = 2'b00;
        v     = 2'b11;
        @(negedge clk);
        check({req0_ready, req1_ready} == 2'b00, "ready_in_reset",
              {req0_ready, req1_ready}, 128'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check(!resp_valid, "abort_resp_valid", resp_valid, 128'd0);
        check(!busy, "abort_busy", busy, 128'd0);
        check(req0_ready && !req1_ready, "abort_ptr_zero",
              {req0_ready, req1_ready}, 128'd2);
        tick();
        v[0] = 1'b0;
        wait_acc(1);
        drain();
        check(last_id == 1'b1, "abort_next_id", last_id, 128'd1);
        check(last_data == mix_ref(sb), "abort_next_data", last_data, mix_ref(sb));

        // Randomized traffic with stalls
        do_reset();
        run_traffic(500, 500, 30, 25);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_col_sched.md
Name: mix_col_sched

Overview:
- Scheduler that shares one 64-bit column-mix datapath (two AES columns per pass) between two requesters.
- Requester 0 is the round-sequencing engine; requester 1 is the RISC-V AES instruction unit.
- Accepts a full 128-bit AES state, runs it through the shared mixer in two beats (high half, then low half) and returns the reassembled 128-bit result with the requester ID.
- Supports a skip flag for the final AES round, where MixColumns is bypassed.

Parameters:
- ID_W, 1, width of the requester ID field; fixed at 1 for two requesters.
- STATE_W, 128, AES state width; must equal 2 x 64.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a state to mix.
- req0_ready  out  1  requester 0 accepted this cycle when valid and ready are both high.
- req0_state  in  128  state; column 0 = [127:96], byte 0 of each column in its MSBs.
- req0_skip  in  1  1 = bypass MixColumns and return the state unchanged.
- req1_valid  in  1  requester 1 valid.
- req1_ready  out  1  requester 1 ready.
- req1_state  in  128  requester 1 state.
- req1_skip  in  1  requester 1 skip.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  128  mixed (or bypassed) state.
- resp_id  out  1  ID of the requester that owns resp_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; resp_valid = 0; resp_data = 0; resp_id = 0; req0_ready = req1_ready = 0 during the reset cycle; busy = 0; priority pointer = 0 (requester 0 favoured).
- Reset asserted mid-operation aborts the operation. The in-flight result is discarded and never presented.
- FSM states: IDLE, MIX_HI, MIX_LO, RESP.
- IDLE, arbitration:
  - Grant is combinational from req0_valid, req1_valid and the priority pointer.
  - A lone valid requester wins.
  - If both requesters are valid, the one indicated by the pointer wins.
  - Only the granted requester sees ready = 1; the loser's ready = 0. Both readys are 0 outside IDLE.
- On accept (valid & ready):
  - Latch state, skip and id.
  - Pointer <= the non-granted requester (round-robin).
  - Next state: MIX_HI if skip = 0; RESP if skip = 1, with resp_data <= state unchanged.
- MIX_HI: drive mixer input = latched state[127:64]; register its output into result[127:64]; next state MIX_LO.
- MIX_LO: drive mixer input = state[63:0]; register output into result[63:0]; next state RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_id held stable until resp_ready.
  - On resp_valid & resp_ready: resp_valid <= 0, next state IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency from the accept edge to resp_valid:
  - Mix: 3 cycles (MIX_HI, MIX_LO, then RESP).
  - Skip: 1 cycle.
- Throughput with resp_ready tied high: one mix per 4 cycles; one skip per 2 cycles.
- Mixer datapath is purely combinational; each beat's output is registered in the same cycle it is driven. No multicycle paths.
- Mixer input is driven to 0 in IDLE and RESP, so the mixer does not toggle while idle.
- Backpressure: a stalled RESP blocks both requesters. Their valids may stay high, and no request is dropped.
- Requesters must hold state/skip stable while valid = 1 and ready = 0. Values are sampled only at the accept edge.
- Starvation bound: a continuously valid requester is granted within 2 arbitration rounds.

Decomposition:
- Shared package aes_pkg:
  - typedef for the 128-bit state and the 64-bit half state.
  - FSM enum {IDLE, MIX_HI, MIX_LO, RESP}.
  - Constant REQ_NUM = 2.
- One sub-module: the existing 64-bit column mixer (mixcol), instantiated once. The scheduler owns all muxing and registers around it.

Test Plan:
- req0 alone, skip = 0, state = db135345_f20a225c_01010101_c6c6c6c6 -> 3 cycles after accept: resp_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, resp_id = 0.
- req1 alone, skip = 1, state = 00112233_44556677_8899aabb_ccddeeff -> 1 cycle after accept: resp_data identical to input, resp_id = 1.
- Both valid every cycle from reset, distinct states, resp_ready = 1 -> grants alternate 0,1,0,1; each resp_id matches the owning state; no request lost.
- State d4d4d4d5_2d26314c_d4d4d4d5_2d26314c; resp_ready held 0 for 5 cycles -> resp_valid and resp_data = d5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8 stable throughout; both readys 0; one handshake when resp_ready rises.
- rst asserted during MIX_LO -> next cycle: IDLE, resp_valid = 0, busy = 0, pointer = 0. A new req1 is then processed normally with its correct result.
- Random states checked against a reference MixColumns model for 1000 operations, with random valid/ready stalls -> all results match and ordering follows round-robin.
